uart_frame_decoder: RTL

// - Sits directly downstream of UART_RX in the bootloader: consumes its byte stream
//   (o_RX_DV / o_RX_Byte) and decodes command frames: 0xA5 | CMD | LEN | LEN payload | CSUM.
// - Streams payload bytes to the flash/command logic, flags frame good/bad, and issues a
//   one-byte ACK (0x06) / NAK (0x15) reply to UART_TX (i_TX_DV / i_TX_Byte).

---
 rtl/uart_frame_decoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_frame_decoder.sv
// Decodes A5|CMD|LEN|payload|CSUM frames from UART_RX; all outputs registered, 1-clk after the byte.
// Reply waits for i_TX_Active low; RX bytes arriving during the reply are dropped.
module uart_frame_decoder #(
   parameter int         MAX_LEN      = 64,
   parameter int         TIMEOUT_CLKS = 250000,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic       i_Clock,
   input  logic       i_Rst_L,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   input  logic       i_TX_Active,
   output logic       o_TX_DV,
   output logic [7:0] o_TX_Byte,
   output logic [7:0] o_Cmd,
   output logic [7:0] o_Len,
   output logic       o_Data_DV,
   output logic [7:0] o_Data_Byte,
   output logic       o_Data_Last,
   output logic       o_Frame_Ok,
   output logic       o_Frame_Err,
   output logic [1:0] o_Err_Code,
   output logic       o_Busy
);

   localparam int          TW        = $clog2(TIMEOUT_CLKS);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [7:0]  ACK_BYTE  = 8'h06;
   localparam logic [7:0]  NAK_BYTE  = 8'h15;

   typedef enum logic [2:0] {
      S_HUNT,
      S_CMD,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_REPLY
   } state_t;

   state_t        state_q;
   logic [7:0]    sum_q;
   logic [7:0]    sum_d;
   logic [7:0]    cnt_q;
   logic [TW-1:0] tmo_q;
   logic [1:0]    rst_sync_q;
   logic          rst_n;
   logic          tx_dv_q;
   logic [7:0]    tx_byte_q;
   logic [7:0]    cmd_q;
   logic [7:0]    len_q;
   logic          data_dv_q;
   logic [7:0]    data_byte_q;
   logic          data_last_q;
   logic          frame_ok_q;
   logic          frame_err_q;
   logic [1:0]    err_code_q;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   assign sum_d = sum_q + i_RX_Byte;

   always_ff @(posedge i_Clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_HUNT;
         sum_q       <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= '0;
         cmd_q       <= '0;
         len_q       <= '0;
         data_dv_q   <= 1'b0;
         data_byte_q <= '0;
         data_last_q <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= '0;
      end else begin
         tx_dv_q     <= 1'b0;
         data_dv_q   <= 1'b0;
         data_last_q <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            S_HUNT: begin
               sum_q <= '0;
               tmo_q <= '0;
               if (i_RX_DV && i_RX_Byte == SYNC_BYTE) state_q <= S_CMD;
            end
            S_CMD, S_LEN, S_DATA, S_CSUM: begin
               // A byte on the terminal timeout cycle takes priority over the abort.
               if (i_RX_DV) begin
                  tmo_q <= '0;
                  case (state_q)
                     S_CMD: begin
                        cmd_q   <= i_RX_Byte;
                        sum_q   <= i_RX_Byte;
                        state_q <= S_LEN;
                     end
                     S_LEN: begin
                        len_q <= i_RX_Byte;
                        sum_q <= sum_d;
                        if (i_RX_Byte == 8'd0) begin
                           state_q <= S_CSUM;
                        end else if (i_RX_Byte > MAX_LEN_B) begin
                           frame_err_q <= 1'b1;
                           err_code_q  <= 2'b10;
                           tx_byte_q   <= NAK_BYTE;
                           state_q     <= S_REPLY;
                        end else begin
                           cnt_q   <= i_RX_Byte;
                           state_q <= S_DATA;
                        end
                     end
                     S_DATA: begin
                        data_dv_q   <= 1'b1;
                        data_byte_q <= i_RX_Byte;
                        sum_q       <= sum_d;
                        cnt_q       <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                           data_last_q <= 1'b1;
                           state_q     <= S_CSUM;
                        end
                     end
                     S_CSUM: begin
                        if (sum_d == 8'd0) begin
                           frame_ok_q <= 1'b1;
                           tx_byte_q  <= ACK_BYTE;
                        end else begin
                           frame_err_q <= 1'b1;
                           err_code_q  <= 2'b01;
                           tx_byte_q   <= NAK_BYTE;
                        end
                        state_q <= S_REPLY;
                     end
                     default: state_q <= S_HUNT;
                  endcase
               end else if (tmo_q == TMO_LAST) begin
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'b11;
                  state_q     <= S_HUNT;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_REPLY: begin
               if (!i_TX_Active) begin
                  tx_dv_q <= 1'b1;
                  state_q <= S_HUNT;
               end
            end
            default: state_q <= S_HUNT;
         endcase
      end
   end

   assign o_TX_DV     = tx_dv_q;
   assign o_TX_Byte   = tx_byte_q;
   assign o_Cmd       = cmd_q;
   assign o_Len       = len_q;
   assign o_Data_DV   = data_dv_q;
   assign o_Data_Byte = data_byte_q;
   assign o_Data_Last = data_last_q;
   assign o_Frame_Ok  = frame_ok_q;
   assign o_Frame_Err = frame_err_q;
   assign o_Err_Code  = err_code_q;
   assign o_Busy      = (state_q != S_HUNT);

endmodule
